// File: rtl/uart_rx_oversampled_if.sv
// Byte-side and line-side signals of the oversampled UART receiver.
// The slave modport is the receiver; the master modport drives the line and tick.
interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output baud_tick,
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  baud_tick,
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver driven by a 16x oversample strobe; mid-bit sampling,
// false-start rejection, and break suppression after a framing error.
module uart_rx_oversampled #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic                  clk,
    input logic                  reset,
    uart_rx_oversampled_if.slave bus
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic [DATA_BITS:0]   shift_in;

    assign shift_in = {rx_s_q, shift_q};

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TickHalf) begin
                        if (!rx_s_q) begin
                            state_d    = StData;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StData: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        shift_d    = shift_in[DATA_BITS:1];
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BitW'(1);
                        if (bit_cnt_q == BitLast) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            StStop: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        rx_data_d = shift_q;
                        if (rx_s_q) begin
                            rx_valid_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
            end
            // Held-low line must return high before another start is accepted.
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= bus.rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: a sample-point model (ticks counted
// from start detection) is compared every cycle, plus literal scenario checks.
module tb_uart_rx_oversampled;
    localparam int OS = 16;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_oversampled_if #(.DATA_BITS(DB)) ifc ();

    uart_rx_oversampled #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    int checks = 0;
    int errors = 0;

    // Model: line delayed two cycles, then sample points at fixed tick offsets.
    int         cyc = 0;
    int         m_mode = 0;  // 0 idle, 1 in frame, 2 line held low after error
    int         m_ticks = 0;
    int         m_k;
    logic       m_s;
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    logic [7:0] m_bits = '0;
    logic [7:0] e_data = '0;
    logic       e_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_s     = m_s2;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (reset) begin
            m_mode = 0;
            e_data = '0;
            m_s1   = 1'b1;
            m_s2   = 1'b1;
        end else begin
            case (m_mode)
                0: if (!m_s) begin
                    m_mode  = 1;
                    m_ticks = 0;
                end
                1: if (ifc.baud_tick) begin
                    m_ticks++;
                    if (m_ticks == OS / 2) begin
                        if (m_s) m_mode = 0;
                    end else if (m_ticks > OS / 2 && (m_ticks - OS / 2) % OS == 0) begin
                        m_k = (m_ticks - OS / 2) / OS;
                        if (m_k <= DB) begin
                            m_bits[m_k-1] = m_s;
                        end else begin
                            e_data = m_bits;
                            if (m_s) begin
                                e_valid = 1'b1;
                                m_mode  = 0;
                            end else begin
                                e_err  = 1'b1;
                                m_mode = 2;
                            end
                        end
                    end
                end
                default: if (m_s) m_mode = 0;
            endcase
            m_s2 = m_s1;
            m_s1 = ifc.rx;
        end
        e_busy = (m_mode != 0);
    end

    int         tick_div = 1;
    int         phase = 0;
    bit         cmp_en = 1'b0;
    int         n_valid = 0;
    int         n_err = 0;
    int         last_valid_cyc = 0;
    logic [7:0] vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare();
        check("rx_valid", 32'(ifc.rx_valid), 32'(e_valid));
        check("frame_err", 32'(ifc.frame_err), 32'(e_err));
        check("busy", 32'(ifc.busy), 32'(e_busy));
        check("rx_data", 32'(ifc.rx_data), 32'(e_data));
        if (ifc.rx_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            vq.push_back(ifc.rx_data);
        end
        if (ifc.frame_err === 1'b1) n_err++;
    endtask

    // One clock: compare at the falling edge, drive just after the rising edge.
    task automatic cyc1();
        @(negedge clk);
        if (cmp_en) compare();
        @(posedge clk);
        #1;
        phase = (phase + 1 >= tick_div) ? 0 : phase + 1;
        ifc.baud_tick = (phase == 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc1();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int blen);
        ifc.rx = 1'b0;
        wait_cycles(blen);
        for (int i = 0; i < 8; i++) begin
            ifc.rx = d[i];
            wait_cycles(blen);
        end
        ifc.rx = stop;
        wait_cycles(blen);
    endtask

    int c0, nv0, ne0, qs0;
    bit dropped;
    logic [7:0] d77;

    initial begin
        reset         = 1'b1;
        ifc.rx        = 1'b1;
        ifc.baud_tick = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        wait_cycles(2);
        check("reset rx_data", 32'(ifc.rx_data), 32'h0);
        check("reset rx_valid", 32'(ifc.rx_valid), 32'h0);
        check("reset frame_err", 32'(ifc.frame_err), 32'h0);
        check("reset busy", 32'(ifc.busy), 32'h0);
        reset = 1'b0;
        wait_cycles(4);

        // Nominal 0xA5, tick every cycle; pulse lands 3 + 152 cycles after the edge.
        tick_div = 1;
        c0  = cyc;
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'hA5, 1'b1, 16);
        wait_cycles(30);
        check("nominal valid count", 32'(n_valid - nv0), 32'd1);
        check("nominal data", 32'(ifc.rx_data), 32'hA5);
        check("nominal err count", 32'(n_err - ne0), 32'd0);
        check("nominal busy after", 32'(ifc.busy), 32'd0);
        check("nominal latency", 32'(last_valid_cyc - c0), 32'd155);

        // Glitch: 4 cycles low is rejected at the mid-start check.
        nv0 = n_valid;
        ne0 = n_err;
        ifc.rx = 1'b0;
        wait_cycles(4);
        ifc.rx = 1'b1;
        wait_cycles(30);
        check("glitch pulses", 32'((n_valid - nv0) + (n_err - ne0)), 32'd0);
        check("glitch data kept", 32'(ifc.rx_data), 32'hA5);
        check("glitch busy", 32'(ifc.busy), 32'd0);

        // Framing error followed by a 40-bit break.
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'h3C, 1'b0, 16);
        wait_cycles(40 * 16);
        check("break err count", 32'(n_err - ne0), 32'd1);
        check("break valid count", 32'(n_valid - nv0), 32'd0);
        check("break data", 32'(ifc.rx_data), 32'h3C);
        check("break busy held", 32'(ifc.busy), 32'd1);
        ifc.rx  = 1'b1;
        c0      = cyc;
        dropped = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc1();
            if (ifc.busy === 1'b0) begin
                dropped = 1'b1;
                break;
            end
        end
        check("break busy dropped", 32'(dropped), 32'd1);
        check("break busy delay", 32'(cyc - c0), 32'd3);
        wait_cycles(20);

        // Back-to-back 0x00 then 0xFF with no idle gap.
        nv0 = n_valid;
        qs0 = vq.size();
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        wait_cycles(40);
        check("b2b valid count", 32'(n_valid - nv0), 32'd2);
        if (vq.size() >= qs0 + 2) begin
            check("b2b first", 32'(vq[qs0]), 32'h00);
            check("b2b second", 32'(vq[qs0+1]), 32'hFF);
        end else begin
            check("b2b queue size", 32'(vq.size() - qs0), 32'd2);
        end

        // Reset during data bit 3 discards the frame.
        d77    = 8'h77;
        ifc.rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 3; i++) begin
            ifc.rx = d77[i];
            wait_cycles(16);
        end
        ifc.rx = d77[3];
        wait_cycles(8);
        reset  = 1'b1;
        ifc.rx = 1'b1;
        cyc1();
        reset = 1'b0;
        check("midreset data", 32'(ifc.rx_data), 32'h0);
        check("midreset busy", 32'(ifc.busy), 32'h0);
        check("midreset valid", 32'(ifc.rx_valid), 32'h0);
        check("midreset err", 32'(ifc.frame_err), 32'h0);
        wait_cycles(32);
        nv0 = n_valid;
        send_frame(8'h5A, 1'b1, 16);
        wait_cycles(40);
        check("after reset count", 32'(n_valid - nv0), 32'd1);
        check("after reset data", 32'(ifc.rx_data), 32'h5A);

        // Real divider: one tick every 131 cycles, nominal and +/-2% bit period.
        tick_div = 131;
        phase    = 0;
        wait_cycles(300);
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'h81, 1'b1, 16 * 131);
        wait_cycles(3 * 131);
        check("divider count", 32'(n_valid - nv0), 32'd1);
        check("divider data", 32'(ifc.rx_data), 32'h81);
        send_frame(8'h81, 1'b1, 2138);
        wait_cycles(3 * 131);
        check("slow count", 32'(n_valid - nv0), 32'd2);
        check("slow data", 32'(ifc.rx_data), 32'h81);
        send_frame(8'h81, 1'b1, 2054);
        wait_cycles(4 * 131);
        check("fast count", 32'(n_valid - nv0), 32'd3);
        check("fast data", 32'(ifc.rx_data), 32'h81);
        check("divider errs", 32'(n_err - ne0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
